fifo_synch_1rnw: RTL

//  Synchronous FIFO: accepts n_write_p words per enqueue, returns one word per dequeue.

---
 rtl/fifo_synch_1rnw.sv | 97 +++++++++
 1 files changed

// File: rtl/fifo_synch_1rnw.sv
// fifo_synch_1rnw
//   Synchronous FIFO with an n_write_p-word enqueue and a one-word dequeue.
//   Wide lane vectors from compute stages go in, and narrow consumers drain
//   them one word at a time. The input uses a valid/ready handshake and the
//   output uses a valid/yumi handshake.
//
// Ports
//   clk_i      clock; all state changes on the rising edge
//   reset_n_i  asynchronous active-low reset
//   data_i     lane vector to enqueue; lane 0 is the oldest word
//   valid_i    producer is presenting data_i
//   ready_o    at least n_write_p slots are free
//   num_i      number of valid lanes (only with FIFO_1RNW_PARTIAL_EN)
//   valid_o    FIFO is non-empty
//   data_o     word at the head of the queue (don't-care while valid_o=0)
//   yumi_i     consumer takes data_o this cycle
//   count_o    current occupancy, 0..cap_p
//
// Build option
//   FIFO_1RNW_PARTIAL_EN  adds num_i, so an enqueue can write fewer than
//                         n_write_p lanes.
module fifo_synch_1rnw #(
   parameter int width_p     = 8,
   parameter int ptr_width_p = 3,
   parameter int n_write_p   = 4
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic [n_write_p-1:0][width_p-1:0] data_i,
   input  logic                              valid_i,
   output logic                              ready_o,
`ifdef FIFO_1RNW_PARTIAL_EN
   input  logic [$clog2(n_write_p+1)-1:0]    num_i,
`endif
   output logic                              valid_o,
   output logic [width_p-1:0]                data_o,
   input  logic                              yumi_i,
   output logic [ptr_width_p:0]              count_o
);

   localparam int cap_p = 1 << ptr_width_p;

   logic [width_p-1:0]   mem [cap_p];
   logic [ptr_width_p:0] rd_ptr, wr_ptr;
   logic [ptr_width_p:0] n_lanes;   // lanes written by the current enqueue
   logic                 ready_en;  // low during reset and until the first edge after release
   logic                 enq, deq;

   // The pointers carry one extra wrap bit, so their difference is the
   // occupancy. This lets the design tell full from empty.
   assign count_o = wr_ptr - rd_ptr;
   assign valid_o = (count_o != '0);
   assign data_o  = mem[rd_ptr[ptr_width_p-1:0]];

   // ready_o uses the current occupancy only. A dequeue in the same cycle
   // does not free a slot early.
   assign ready_o = ready_en && ((cap_p - int'(count_o)) >= n_write_p);
   assign deq     = valid_o & yumi_i;

`ifdef FIFO_1RNW_PARTIAL_EN
   // An out-of-range lane count is clamped to n_write_p, so a vector can
   // never write more lanes than it has. num_i=0 writes nothing.
   always_comb begin
      n_lanes = (ptr_width_p+1)'(n_write_p);
      if (int'(num_i) < n_write_p)
         n_lanes = (ptr_width_p+1)'(num_i);
   end
   assign enq = valid_i & ready_o & (n_lanes != '0);
`else
   assign n_lanes = (ptr_width_p+1)'(n_write_p);
   assign enq     = valid_i & ready_o;
`endif

   // The storage is not reset. Lane slot addresses wrap modulo cap_p, so a
   // vector may straddle the end of the array.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         for (int k = 0; k < n_write_p; k++) begin
            if (k < int'(n_lanes))
               mem[wr_ptr[ptr_width_p-1:0] + ptr_width_p'(k)] <= data_i[k];
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (enq) wr_ptr <= wr_ptr + n_lanes;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule
